uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 SHALL have port clk  input  1: single clock for all state.
REQ-003 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  NUM_REQ: requester i has a byte pending.
REQ-005 SHALL have port req_byte  input  8*NUM_REQ: byte of requester i in bits [8i+7:8i].
REQ-006 SHALL have port req_ready  output  NUM_REQ: one-cycle acceptance pulse to requester i.
REQ-007 SHALL have port req_lock  input  NUM_REQ: packet-lock request; present only with UART_TX_ARB_LOCK_EN.
REQ-008 SHALL have port tx_dv  output  1: one-cycle start strobe to uart_tx.
REQ-009 SHALL have port tx_byte  output  8: byte to uart_tx, valid while tx_dv=1.
REQ-010 SHALL have port tx_active  input  1: uart_tx busy.
REQ-011 SHALL have port tx_done  input  1: uart_tx done; high for up to 2 consecutive cycles per byte.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ): index of the current or last granted requester.
REQ-013 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE and DRAIN.
REQ-015 IDLE with any eligible req_valid: SHALL select the winner, capture its byte, set grant_id, pulse req_ready[winner] for 1 cycle and go to ISSUE.
REQ-016 ISSUE: SHALL drive tx_dv=1 with the captured tx_byte for exactly 1 cycle, then go to WAIT_DONE.
REQ-017 WAIT_DONE: SHALL stay until tx_done=1, then go to DRAIN.
REQ-018 DRAIN: SHALL stay until tx_done=0 and tx_active=0, then go to IDLE, so a 2-cycle done never double-counts.
REQ-019 Minimum spacing from a req_ready pulse to the next req_ready pulse SHALL be set by uart_tx completion; no byte is issued while tx_active=1.
REQ-020 Arbitration SHALL be round-robin: the search starts at last_grant+1 modulo NUM_REQ; the first requester with req_valid=1 wins.
REQ-021 A requester SHALL hold req_valid and req_byte stable until its req_ready pulse; the arbiter samples req_byte only in the cycle req_ready is asserted.
REQ-022 req_valid deasserted before acceptance SHALL withdraw the request with no side effect.
REQ-023 At most one req_ready bit SHALL be high in any cycle.
REQ-024 tx_dv SHALL never be high in two consecutive cycles.
REQ-025 tx_done=1 outside WAIT_DONE and DRAIN SHALL be ignored.
REQ-026 last_grant SHALL update only on acceptance; wrap from NUM_REQ-1 to 0.

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, tx_dv=0, tx_byte=0, req_ready=0, grant_id=0, busy=0, last_grant=NUM_REQ-1 (requester 0 has first priority), lock cleared.
REQ-028 Reset mid-transfer SHALL abort with no req_ready or tx_dv glitch; uart_tx shares the same reset.

Configuration
REQ-029 With macro UART_TX_ARB_LOCK_EN defined: if req_lock[winner]=1 at acceptance, the arbiter SHALL record the lock and consider only that requester in IDLE until it is accepted with req_lock=0, or req_lock drops while it is not pending.
REQ-030 With UART_TX_ARB_LOCK_EN undefined: there SHALL be no req_lock port and no lock state, and arbitration is pure round-robin.

Structure
REQ-031 A shared package uart_tx_arb_pkg SHALL hold the FSM state enum and the NUM_REQ maximum constant.
REQ-032 A sub-module rr_picker SHALL be used: combinational round-robin winner plus a found flag, from request vector and last_grant.

Verification
REQ-033 Single request: reset then req_valid=0001, byte 8'hA5 -> req_ready[0] pulse, tx_dv 1 cycle later with tx_byte=A5, busy until tx_done falls.
REQ-034 All requesters: req_valid=1111 held, bytes 10/11/12/13 -> tx_byte order 10,11,12,13,10.
REQ-035 Two-cycle done: tx_done high 2 cycles -> exactly one completion and one subsequent grant.
REQ-036 Reset mid-WAIT_DONE: assert reset -> all outputs 0 immediately; after release, requester 0 is served first.
REQ-037 Lock (macro on): req 2 sends 3 bytes with req_lock=1,1,0 while req 0/1 are valid -> bytes of req 2 are contiguous, then req 0 is served.
REQ-038 Withdraw: req_valid[1] pulsed for 1 cycle while busy -> no req_ready[1] and no issue.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and limits for the uart_tx arbiter.
package uart_tx_arb_pkg;

    localparam int unsigned NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        DRAIN     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request after last_i,
// wrapping modulo N.
module rr_picker #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_i,
    output logic [IDW-1:0] winner_o,
    output logic           found_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = IDW'((32'(last_i) + off) % N);
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// Define UART_TX_ARB_LOCK_EN to add the req_lock port and packet locking.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_byte,
    output logic [NUM_REQ-1:0]         req_ready,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic                       tx_dv,
    output logic [7:0]                 tx_byte,
    input  logic                       tx_active,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ out of range");
    end

    arb_state_e           state_q, state_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic [NUM_REQ-1:0]   accept_oh;
    logic [NUM_REQ-1:0]   eligible;
    logic [IDW-1:0]       pick;
    logic                 found;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic [NUM_REQ-1:0] lock_mask;

    // While locked, only the last granted requester may compete.
    always_comb begin
        lock_mask               = '0;
        lock_mask[last_grant_q] = 1'b1;
        eligible                = lock_q ? (req_valid & lock_mask) : req_valid;
    end
`else
    assign eligible = req_valid;
`endif

    rr_picker #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_picker (
        .req_i    (eligible),
        .last_i   (last_grant_q),
        .winner_o (pick),
        .found_o  (found)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_byte_d    = tx_byte_q;
        accept_oh    = '0;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d = lock_q;
        if (lock_q && !req_valid[last_grant_q] && !req_lock[last_grant_q]) begin
            lock_d = 1'b0;
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (found && !tx_active) begin
                    accept_oh[pick] = 1'b1;
                    tx_byte_d       = req_byte[{pick, 3'b000} +: 8];
                    grant_id_d      = pick;
                    last_grant_d    = pick;
                    state_d         = ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d = req_lock[pick];
`endif
                end
            end
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: if (tx_done) state_d = DRAIN;
            DRAIN:     if (!tx_done && !tx_active) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_byte_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_byte_q    <= tx_byte_d;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end
`endif

    // Acceptance is decoded from IDLE, which is also the reset state, so it is
    // masked by reset to keep req_ready quiet while reset is held.
    assign req_ready = accept_oh & {NUM_REQ{~reset}};
    assign tx_dv     = (state_q == ISSUE);
    assign tx_byte   = tx_byte_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx and
// queue-driven requesters.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned N       = 4;
    localparam int unsigned ACT_CYC = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_byte;
    logic [N-1:0]   req_ready;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N-1:0]   req_lock;
`endif
    logic           tx_dv;
    logic [7:0]     tx_byte;
    logic           tx_active;
    logic           tx_done;
    logic [1:0]     grant_id;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic [8:0]  rmem [N][8];
    int unsigned rhead [N];
    int unsigned rtail [N];
    logic [N-1:0] extra_valid;
    logic [7:0]   extra_byte;
    logic [9:0]   exp_q [$];
    int unsigned  done_len;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_byte  (req_byte),
        .req_ready (req_ready),
`ifdef UART_TX_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    task automatic push_req(input int unsigned id, input logic [7:0] b, input logic lk);
        rmem[id][rtail[id]] = {lk, b};
        rtail[id]++;
    endtask

    task automatic expect_tx(input logic [1:0] id, input logic [7:0] b);
        exp_q.push_back({id, b});
    endtask

    function automatic bit reqs_pending();
        bit p = 1'b0;
        for (int unsigned i = 0; i < N; i++) if (rhead[i] != rtail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic driver_loop();
        logic [N-1:0] rdy_s;
        forever begin
            @(negedge clk);
            rdy_s = req_ready;
            @(posedge clk);
            #1;
            for (int unsigned i = 0; i < N; i++) begin
                if (rdy_s[i] && rhead[i] != rtail[i]) rhead[i]++;
                if (rhead[i] != rtail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_byte[8*i +: 8] = rmem[i][rhead[i]][7:0];
`ifdef UART_TX_ARB_LOCK_EN
                    req_lock[i]        = rmem[i][rhead[i]][8];
`endif
                end else begin
                    req_valid[i]       = extra_valid[i];
                    req_byte[8*i +: 8] = extra_valid[i] ? extra_byte : 8'h00;
`ifdef UART_TX_ARB_LOCK_EN
                    req_lock[i]        = 1'b0;
`endif
                end
            end
        end
    endtask

    task automatic uart_loop();
        int unsigned cnt  = 0;
        int unsigned dcnt = 0;
        logic dv_seen;
        forever begin
            @(negedge clk);
            dv_seen = tx_dv;
            @(posedge clk);
            #1;
            if (reset) begin
                tx_active = 1'b0;
                tx_done   = 1'b0;
                cnt       = 0;
                dcnt      = 0;
            end else begin
                if (dcnt != 0) begin
                    dcnt--;
                    if (dcnt == 0) tx_done = 1'b0;
                end
                if (cnt != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        tx_active = 1'b0;
                        tx_done   = 1'b1;
                        dcnt      = done_len;
                    end
                end
                if (dv_seen) begin
                    tx_active = 1'b1;
                    cnt       = ACT_CYC;
                end
            end
        end
    endtask

    task automatic monitor_loop();
        logic         dv_prev = 1'b0;
        logic [N-1:0] ready_prev = '0;
        logic [N-1:0] oh;
        logic [9:0]   e;
        forever begin
            @(negedge clk);
            if (reset) begin
                dv_prev    = 1'b0;
                ready_prev = '0;
            end else begin
                if (tx_active || tx_done) chk("busy_during_tx", 32'(busy), 32'd1);
                if (req_ready != '0) begin
                    chk("ready_onehot", $countones(req_ready), 32'd1);
                    chk("ready_while_uart_busy", 32'(tx_active | tx_done), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", 32'(req_ready), 32'd0);
                    end else begin
                        e         = exp_q[0];
                        oh        = '0;
                        oh[e[9:8]] = 1'b1;
                        chk("ready_id", 32'(req_ready), 32'(oh));
                    end
                end
                if (tx_dv) begin
                    chk("dv_back_to_back", 32'(dv_prev), 32'd0);
                    chk("dv_follows_ready", 32'(ready_prev != '0), 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tx_dv_byte", 32'(tx_byte), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", 32'(tx_byte), 32'(e[7:0]));
                        chk("grant_id", 32'(grant_id), 32'(e[9:8]));
                    end
                end
                dv_prev    = tx_dv;
                ready_prev = req_ready;
            end
        end
    endtask

    task automatic do_reset(input string name);
        reset       = 1'b1;
        tx_active   = 1'b0;
        tx_done     = 1'b0;
        extra_valid = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        exp_q.delete();
        #1;
        chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_tx_dv"},     32'(tx_dv),     32'd0);
        chk({name, "_tx_byte"},   32'(tx_byte),   32'd0);
        chk({name, "_grant_id"},  32'(grant_id),  32'd0);
        chk({name, "_busy"},      32'(busy),      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        bit pend;
        do begin
            @(negedge clk);
            n++;
            pend = (exp_q.size() != 0) || busy || reqs_pending();
        end while (pend && n < 2000);
        repeat (4) @(negedge clk);
        checks++;
        if (pend || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected bytes left, busy=%0b, required 0 left and idle",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic wait_active(input string name);
        int unsigned n = 0;
        while (!tx_active && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_uart_started"}, 32'(tx_active), 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_byte    = '0;
`ifdef UART_TX_ARB_LOCK_EN
        req_lock    = '0;
`endif
        tx_active   = 1'b0;
        tx_done     = 1'b0;
        extra_valid = '0;
        extra_byte  = 8'h00;
        done_len    = 1;
        for (int unsigned i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end

        fork
            driver_loop();
            uart_loop();
            monitor_loop();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        do_reset("por");

        // single request from requester 0
        push_req(0, 8'hA5, 1'b0);
        expect_tx(2'd0, 8'hA5);
        wait_idle("single");

        // all requesters held valid: rotation wraps back to 0
        do_reset("rst_all");
        push_req(0, 8'h10, 1'b0);
        push_req(0, 8'h10, 1'b0);
        push_req(1, 8'h11, 1'b0);
        push_req(2, 8'h12, 1'b0);
        push_req(3, 8'h13, 1'b0);
        expect_tx(2'd0, 8'h10);
        expect_tx(2'd1, 8'h11);
        expect_tx(2'd2, 8'h12);
        expect_tx(2'd3, 8'h13);
        expect_tx(2'd0, 8'h10);
        wait_idle("all");

        // two-cycle tx_done
        do_reset("rst_done2");
        done_len = 2;
        push_req(1, 8'h31, 1'b0);
        push_req(2, 8'h32, 1'b0);
        expect_tx(2'd1, 8'h31);
        expect_tx(2'd2, 8'h32);
        wait_idle("done2");
        done_len = 1;

        // reset in WAIT_DONE after granting requester 0
        do_reset("rst_pre_abort");
        push_req(0, 8'h55, 1'b0);
        expect_tx(2'd0, 8'h55);
        wait_active("abort");
        #2;
        do_reset("rst_abort");
        push_req(0, 8'h60, 1'b0);
        push_req(1, 8'h61, 1'b0);
        expect_tx(2'd0, 8'h60);
        expect_tx(2'd1, 8'h61);
        wait_idle("after_abort");

        // requester 1 pulses valid for one cycle while busy
        do_reset("rst_withdraw");
        push_req(3, 8'h93, 1'b0);
        expect_tx(2'd3, 8'h93);
        wait_active("withdraw");
        @(posedge clk);
        extra_byte  = 8'hEE;
        extra_valid = 4'b0010;
        @(posedge clk);
        extra_valid = '0;
        wait_idle("withdraw");

`ifdef UART_TX_ARB_LOCK_EN
        // locked 3-byte packet from requester 2 with 0 and 1 waiting
        do_reset("rst_lock");
        push_req(1, 8'h71, 1'b0);
        expect_tx(2'd1, 8'h71);
        wait_idle("lock_pre");
        push_req(2, 8'hB0, 1'b1);
        push_req(2, 8'hB1, 1'b1);
        push_req(2, 8'hB2, 1'b0);
        push_req(0, 8'h70, 1'b0);
        push_req(1, 8'h72, 1'b0);
        expect_tx(2'd2, 8'hB0);
        expect_tx(2'd2, 8'hB1);
        expect_tx(2'd2, 8'hB2);
        expect_tx(2'd0, 8'h70);
        expect_tx(2'd1, 8'h72);
        wait_idle("lock");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
